disp_msg_scroller: RTL and testbench



---
 rtl/disp_pkg.sv | 27 ++
 rtl/disp_msg_scroller_if.sv | 29 ++
 rtl/char7seg_decode.sv | 44 ++++
 rtl/disp_msg_scroller.sv | 103 ++++++++++
 tb/tb_disp_msg_scroller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display message scroller: character codes,
// FSM state encoding and default geometry.
package disp_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CHAR_W_DEF  = 5;
    localparam int LEN_W_DEF   = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Codes 0x00-0x0F are the hex digits themselves.
    localparam logic [4:0] CH_BLANK = 5'h10;
    localparam logic [4:0] CH_DASH  = 5'h11;
    localparam logic [4:0] CH_P     = 5'h12;
    localparam logic [4:0] CH_S     = 5'h13;
    localparam logic [4:0] CH_L     = 5'h14;
    localparam logic [4:0] CH_R     = 5'h15;
    localparam logic [4:0] CH_O     = 5'h16;
    localparam logic [4:0] CH_N     = 5'h17;
    localparam logic [4:0] CH_U     = 5'h18;
    localparam logic [4:0] CH_H     = 5'h19;
    localparam logic [4:0] CH_I     = 5'h1A;

endpackage

// File: rtl/disp_msg_scroller_if.sv
// Controller-to-scroller bundle: message load, advance tick and the
// digit/status outputs.
interface disp_msg_scroller_if #(
    parameter int MAX_LEN = 8,
    parameter int CHAR_W  = 5,
    parameter int LEN_W   = 4
) ();
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic                      tick;
    logic                      load;
    logic [MAX_LEN*CHAR_W-1:0] msg_in;
    logic [LEN_W-1:0]          msg_len;
    logic                      repeat_en;
    logic [6:0]                seg;
    logic [IDX_W-1:0]          char_idx;
    logic                      busy;
    logic                      done;

    modport master (
        output tick, load, msg_in, msg_len, repeat_en,
        input  seg, char_idx, busy, done
    );

    modport slave (
        input  tick, load, msg_in, msg_len, repeat_en,
        output seg, char_idx, busy, done
    );
endinterface

// File: rtl/char7seg_decode.sv
// Combinational 5-bit character code to 7-segment {g,f,e,d,c,b,a} decode,
// active-high; unassigned codes blank the digit.
module char7seg_decode
    import disp_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_code)
            5'h00:    o_seg = 7'h3F;
            5'h01:    o_seg = 7'h06;
            5'h02:    o_seg = 7'h5B;
            5'h03:    o_seg = 7'h4F;
            5'h04:    o_seg = 7'h66;
            5'h05:    o_seg = 7'h6D;
            5'h06:    o_seg = 7'h7D;
            5'h07:    o_seg = 7'h07;
            5'h08:    o_seg = 7'h7F;
            5'h09:    o_seg = 7'h6F;
            5'h0A:    o_seg = 7'h77;
            5'h0B:    o_seg = 7'h7C;
            5'h0C:    o_seg = 7'h39;
            5'h0D:    o_seg = 7'h5E;
            5'h0E:    o_seg = 7'h79;
            5'h0F:    o_seg = 7'h71;
            CH_BLANK: o_seg = 7'h00;
            CH_DASH:  o_seg = 7'h40;
            CH_P:     o_seg = 7'h73;
            CH_S:     o_seg = 7'h6D;
            CH_L:     o_seg = 7'h38;
            CH_R:     o_seg = 7'h50;
            CH_O:     o_seg = 7'h5C;
            CH_N:     o_seg = 7'h54;
            CH_U:     o_seg = 7'h3E;
            CH_H:     o_seg = 7'h76;
            CH_I:     o_seg = 7'h06;
            default:  o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/disp_msg_scroller.sv
// Scrolls a latched character message across one 7-segment digit, one
// character per display tick, with optional wrap-around for banners.
module disp_msg_scroller
    import disp_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input logic               clk,
    input logic               rst,
    disp_msg_scroller_if.slave bus
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [MAX_LEN*CHAR_W-1:0] r_buf;
    logic [LEN_W-1:0]          r_len;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_done;
    logic [6:0]                r_seg;

    logic                      w_load_ok;
    logic                      w_last;
    logic                      w_adv;
    logic                      w_end_pass;
    logic [LEN_W-1:0]          w_eff_len;
    logic [CHAR_W-1:0]         w_char;
    logic [6:0]                w_seg_dec;

    assign w_load_ok = bus.load && (bus.msg_len != '0);
    assign w_eff_len = (bus.msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.msg_len;
    assign w_last    = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
    assign w_char    = r_buf[r_idx*CHAR_W +: CHAR_W];

    char7seg_decode u_dec (
        .i_code (w_char[4:0]),
        .o_seg  (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A valid load overrides any tick in the same cycle, so an aborted
    // message never produces a done pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_end_pass  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load_ok) w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (!w_load_ok && bus.tick) begin
                    if (w_last) begin
                        w_end_pass = 1'b1;
                        if (!bus.repeat_en) w_state_nxt = ST_IDLE;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_seg  <= 7'h00;
        end else begin
            r_done <= w_end_pass;
            if (w_load_ok) begin
                r_buf <= bus.msg_in;
                r_len <= w_eff_len;
                r_idx <= '0;
            end else if (w_end_pass) begin
                r_idx <= '0;
            end else if (w_adv) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // seg trails char_idx by one cycle and blanks one cycle after busy drops
            r_seg <= (r_state == ST_SHOW) ? w_seg_dec : 7'h00;
        end
    end

    assign bus.seg      = r_seg;
    assign bus.char_idx = r_idx;
    assign bus.busy     = (r_state == ST_SHOW);
    assign bus.done     = r_done;

endmodule

// File: tb/tb_disp_msg_scroller.sv
// Scoreboard bench for disp_msg_scroller: a behavioural model queues the
// expected outputs each edge and the negedge checker compares them.
module tb_disp_msg_scroller;

    logic clk;
    logic rst;

    disp_msg_scroller_if #(.MAX_LEN(8), .CHAR_W(5), .LEN_W(4)) bus ();

    disp_msg_scroller #(.MAX_LEN(8), .CHAR_W(5), .LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    logic [6:0] tbl [32];
    logic [4:0] m_buf [8];
    int         m_len;
    int         m_idx;
    logic       m_show;
    logic       m_done;
    logic [6:0] m_seg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tbl[i] = 7'h00;
        tbl[0]  = 7'h3F; tbl[1]  = 7'h06; tbl[2]  = 7'h5B; tbl[3]  = 7'h4F;
        tbl[4]  = 7'h66; tbl[5]  = 7'h6D; tbl[6]  = 7'h7D; tbl[7]  = 7'h07;
        tbl[8]  = 7'h7F; tbl[9]  = 7'h6F; tbl[10] = 7'h77; tbl[11] = 7'h7C;
        tbl[12] = 7'h39; tbl[13] = 7'h5E; tbl[14] = 7'h79; tbl[15] = 7'h71;
        tbl[16] = 7'h00; tbl[17] = 7'h40; tbl[18] = 7'h73; tbl[19] = 7'h6D;
        tbl[20] = 7'h38; tbl[21] = 7'h50; tbl[22] = 7'h5C; tbl[23] = 7'h54;
        tbl[24] = 7'h3E; tbl[25] = 7'h76; tbl[26] = 7'h06;
    end

    // Reference model: evaluated on each edge from the inputs held stable since posedge+1.
    always @(posedge clk) begin
        logic [6:0] nseg;
        if (rst) begin
            for (int k = 0; k < 8; k++) m_buf[k] = 5'h00;
            m_len  = 0;
            m_idx  = 0;
            m_show = 1'b0;
            m_done = 1'b0;
            m_seg  = 7'h00;
        end else begin
            nseg   = m_show ? tbl[m_buf[m_idx]] : 7'h00;
            m_done = 1'b0;
            if (bus.load && bus.msg_len != 0) begin
                for (int k = 0; k < 8; k++) m_buf[k] = bus.msg_in[k*5 +: 5];
                m_len  = (bus.msg_len > 8) ? 8 : int'(bus.msg_len);
                m_idx  = 0;
                m_show = 1'b1;
            end else if (m_show && bus.tick) begin
                if (m_idx == m_len - 1) begin
                    m_idx  = 0;
                    m_done = 1'b1;
                    if (!bus.repeat_en) m_show = 1'b0;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
            m_seg = nseg;
        end
        sb.push_back('{seg: m_seg, idx: 3'(m_idx), busy: m_show, done: m_done});
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("seg",      32'(bus.seg),      32'(e.seg));
            chk("char_idx", 32'(bus.char_idx), 32'(e.idx));
            chk("busy",     32'(bus.busy),     32'(e.busy));
            chk("done",     32'(bus.done),     32'(e.done));
            if (bus.done) n_done++;
        end
    end

    function automatic logic [39:0] pack4(input logic [4:0] c0, c1, c2, c3);
        return {20'h0, c3, c2, c1, c0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        cyc(9);
    endtask

    task automatic do_load(input logic [39:0] msg, input logic [3:0] len, input logic with_tick);
        bus.load    = 1'b1;
        bus.msg_in  = msg;
        bus.msg_len = len;
        bus.tick    = with_tick;
        cyc(1);
        bus.load = 1'b0;
        bus.tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic [39:0] pass_m;
        logic [39:0] fail_m;
        logic [39:0] lock_m;
        pass_m = pack4(5'h12, 5'h0A, 5'h13, 5'h13);
        fail_m = pack4(5'h0F, 5'h0A, 5'h1A, 5'h14);
        lock_m = pack4(5'h14, 5'h16, 5'h0C, 5'h0C);

        rst = 1'b1;
        bus.tick = 1'b0; bus.load = 1'b0; bus.msg_in = '0;
        bus.msg_len = '0; bus.repeat_en = 1'b0;
        cyc(3);
        chk("rst_seg",  32'(bus.seg),  32'h00);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        cyc(2);

        // PASS, single pass
        d0 = n_done;
        do_load(pass_m, 4'd4, 1'b0);
        cyc(2);
        chk("pass_first_seg", 32'(bus.seg), 32'h73);
        for (int i = 0; i < 4; i++) do_tick();
        chk("pass_dones", 32'(n_done - d0), 32'd1);
        chk("pass_busy_end", 32'(bus.busy), 32'd0);
        chk("pass_seg_end", 32'(bus.seg), 32'h00);

        // PASS, repeat mode
        bus.repeat_en = 1'b1;
        d0 = n_done;
        do_load(pass_m, 4'd4, 1'b0);
        cyc(3);
        for (int i = 0; i < 9; i++) do_tick();
        chk("rep_dones", 32'(n_done - d0), 32'd2);
        chk("rep_busy", 32'(bus.busy), 32'd1);
        bus.repeat_en = 1'b0;
        for (int i = 0; i < 3; i++) do_tick();
        chk("rep_stop_busy", 32'(bus.busy), 32'd0);

        // zero-length loads, idle and mid-scroll
        d0 = n_done;
        do_load(pass_m, 4'd0, 1'b0);
        cyc(3);
        chk("len0_idle_busy", 32'(bus.busy), 32'd0);
        do_load(pass_m, 4'd4, 1'b0);
        cyc(3);
        do_tick();
        do_load(fail_m, 4'd0, 1'b0);
        cyc(2);
        chk("len0_show_idx", 32'(bus.char_idx), 32'd1);
        for (int i = 0; i < 3; i++) do_tick();
        chk("len0_dones", 32'(n_done - d0), 32'd1);

        // FAIL with over-long length clamps to 8
        d0 = n_done;
        do_load(fail_m, 4'd12, 1'b0);
        cyc(3);
        for (int i = 0; i < 7; i++) do_tick();
        chk("fail_seg7", 32'(bus.seg), 32'h3F);
        chk("fail_nodone7", 32'(n_done - d0), 32'd0);
        do_tick();
        chk("fail_dones", 32'(n_done - d0), 32'd1);

        // load beats tick mid-scroll
        d0 = n_done;
        do_load(pass_m, 4'd4, 1'b0);
        cyc(3);
        do_tick(); do_tick();
        do_load(lock_m, 4'd4, 1'b1);
        chk("lock_idx", 32'(bus.char_idx), 32'd0);
        cyc(1);
        chk("lock_seg", 32'(bus.seg), 32'h38);
        chk("lock_nodone", 32'(n_done - d0), 32'd0);

        // reset coincident with tick at char 3
        for (int i = 0; i < 3; i++) do_tick();
        rst = 1'b1; bus.tick = 1'b1;
        cyc(1);
        rst = 1'b0; bus.tick = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_seg", 32'(bus.seg), 32'h00);
        for (int i = 0; i < 3; i++) do_tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.tick      = ($urandom_range(0, 2) == 0);
            bus.load      = ($urandom_range(0, 24) == 0);
            bus.msg_len   = 4'($urandom_range(0, 10));
            bus.msg_in    = {8'($urandom), 32'($urandom)};
            if ($urandom_range(0, 30) == 0) bus.repeat_en = ~bus.repeat_en;
            cyc(1);
        end
        bus.tick = 1'b0; bus.load = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
